contador_32: RTL and testbench



---
 rtl/contador_32_if.sv | 13 +
 rtl/contador_32.sv | 65 ++++++
 tb/tb_contador_32.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/contador_32_if.sv
// Bus bundle for contador_32: enable/mode/load data in, count/wrap flag/load status out.
// The master drives the control side and the counter (slave) drives the results.
interface contador_32_if;
    logic        ENABLE;
    logic [1:0]  MODO;
    logic [31:0] D;
    logic [31:0] Q;
    logic        RCO;
    logic [7:0]  LOAD;

    modport master (output ENABLE, MODO, D, input Q, RCO, LOAD);
    modport slave  (input ENABLE, MODO, D, output Q, RCO, LOAD);
endinterface

// File: rtl/contador_32.sv
// 32-bit up/down counter with parallel load, built from eight cascaded 4-bit slices.
// MODO: 00 up 1, 01 down 1, 10 down 3, 11 load D. RCO is the carry/borrow out of slice 7.
module contador_32 (
    input  logic         clk,
    input  logic         RESET,
    contador_32_if.slave bus
);

    logic [31:0] q_r;
    logic        rco_r;
    logic [7:0]  load_r;

    logic        sub;
    logic [3:0]  step;
    logic [3:0]  operand;
    logic [4:0]  slice;
    logic [8:0]  chain;
    logic [31:0] next_count;

    assign sub  = (bus.MODO == 2'b01) || (bus.MODO == 2'b10);
    assign step = (bus.MODO == 2'b10) ? 4'd3 : 4'd1;

    // Only slice 0 sees the step; higher slices just absorb the rippling carry or borrow.
    always_comb begin
        chain      = '0;
        next_count = '0;
        operand    = '0;
        slice      = '0;
        for (int i = 0; i < 8; i++) begin
            operand = (i == 0) ? step : 4'h0;
            if (sub)
                slice = {1'b0, q_r[4*i +: 4]} - {1'b0, operand} - {4'h0, chain[i]};
            else
                slice = {1'b0, q_r[4*i +: 4]} + {1'b0, operand} + {4'h0, chain[i]};
            next_count[4*i +: 4] = slice[3:0];
            chain[i+1]           = slice[4];
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            q_r    <= '0;
            rco_r  <= 1'b0;
            load_r <= '0;
        end else if (bus.ENABLE) begin
            if (bus.MODO == 2'b11) begin
                q_r    <= bus.D;
                rco_r  <= 1'b0;
                load_r <= 8'hFF;
            end else begin
                q_r    <= next_count;
                rco_r  <= chain[8];
                load_r <= 8'h00;
            end
        end else begin
            rco_r  <= 1'b0;
            load_r <= 8'h00;
        end
    end

    assign bus.Q    = q_r;
    assign bus.RCO  = rco_r;
    assign bus.LOAD = load_r;

endmodule

// File: tb/tb_contador_32.sv
// Directed bench for contador_32: reset, load, wrap in every mode, enable hold and slice ripple.
module tb_contador_32;

    logic clk;
    logic RESET;
    int   checks;
    int   failures;

    contador_32_if bus ();

    contador_32 dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] q, input logic rco, input logic [7:0] load);
        check({tag, "_q"}, bus.Q, q);
        check({tag, "_rco"}, 32'(bus.RCO), 32'(rco));
        check({tag, "_load"}, 32'(bus.LOAD), 32'(load));
    endtask

    task automatic load_value(input logic [31:0] v);
        bus.ENABLE = 1'b1;
        bus.MODO   = 2'b11;
        bus.D      = v;
        tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RESET      = 1'b0;
        bus.ENABLE = 1'b0;
        bus.MODO   = 2'b00;
        bus.D      = '0;

        #12;
        check_all("reset_init", 32'h0, 1'b0, 8'h00);
        @(negedge clk);
        RESET = 1'b1;

        // Load 0x1234 and count once, then reset asynchronously mid-cycle.
        load_value(32'h1234);
        check_all("load_1234", 32'h1234, 1'b0, 8'hFF);
        bus.MODO = 2'b00;
        tick();
        check_all("count_1235", 32'h1235, 1'b0, 8'h00);
        #2;
        RESET = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 1'b0, 8'h00);
        tick();
        check_all("reset_held", 32'h0, 1'b0, 8'h00);
        @(negedge clk);
        RESET = 1'b1;
        bus.ENABLE = 1'b1;
        bus.MODO   = 2'b00;
        tick();
        tick();
        tick();
        check_all("up_after_reset", 32'h3, 1'b0, 8'h00);

        // Load then wrap upward.
        load_value(32'hFFFFFFFE);
        check_all("load_fffffffe", 32'hFFFFFFFE, 1'b0, 8'hFF);
        bus.MODO = 2'b00;
        tick();
        check_all("up_e1", 32'hFFFFFFFF, 1'b0, 8'h00);
        tick();
        check_all("up_wrap", 32'h0, 1'b1, 8'h00);
        tick();
        check_all("up_e3", 32'h1, 1'b0, 8'h00);

        // Down by one through zero.
        load_value(32'h1);
        bus.MODO = 2'b01;
        tick();
        check_all("dn1_e1", 32'h0, 1'b0, 8'h00);
        tick();
        check_all("dn1_wrap", 32'hFFFFFFFF, 1'b1, 8'h00);

        // Down by three with borrow on the third step.
        load_value(32'd7);
        bus.MODO = 2'b10;
        tick();
        check_all("dn3_e1", 32'd4, 1'b0, 8'h00);
        tick();
        check_all("dn3_e2", 32'd1, 1'b0, 8'h00);
        tick();
        check_all("dn3_wrap", 32'hFFFFFFFE, 1'b1, 8'h00);
        tick();
        check_all("dn3_e4", 32'hFFFFFFFB, 1'b0, 8'h00);

        // Down by three from zero.
        load_value(32'h0);
        bus.MODO = 2'b10;
        tick();
        check_all("dn3_from0", 32'hFFFFFFFD, 1'b1, 8'h00);

        // Enable low: nothing moves regardless of mode.
        load_value(32'hA5A5A5A5);
        check_all("load_a5", 32'hA5A5A5A5, 1'b0, 8'hFF);
        bus.ENABLE = 1'b0;
        bus.D      = 32'h12345678;
        for (int m = 0; m < 4; m++) begin
            bus.MODO = 2'(m);
            tick();
            check_all($sformatf("hold_m%0d", m), 32'hA5A5A5A5, 1'b0, 8'h00);
        end

        // Back-to-back loads keep LOAD asserted.
        load_value(32'h11111111);
        load_value(32'h22222222);
        check_all("load_again", 32'h22222222, 1'b0, 8'hFF);

        // Carry and borrow rippling across slice boundaries.
        load_value(32'h0000FFFF);
        bus.MODO = 2'b00;
        tick();
        check_all("ripple_up", 32'h00010000, 1'b0, 8'h00);
        bus.MODO = 2'b01;
        tick();
        check_all("ripple_dn", 32'h0000FFFF, 1'b0, 8'h00);
        load_value(32'h10000001);
        bus.MODO = 2'b10;
        tick();
        check_all("ripple_dn3", 32'h0FFFFFFE, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
